operand_load_handler: RTL and testbench
=======================================

Name: operand_load_handler

Overview:
- Upstream neighbour of the data-memory write stage; fetches up to two operands from the synchronous data memory for the current instruction.
- Presents the fetched operands, with a one-cycle `ready` pulse, to the execute and save path.
- Level-enabled by the controller, as the save stage is; sequences memory reads with a fixed one-cycle read latency.

Parameters:
- DATA_WIDTH, 8, operand/memory word width
- DATA_MEMORY_SIZE, 64, words in data memory; address width AW = $clog2(DATA_MEMORY_SIZE)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level request from controller; deassert aborts
- need_b  in  1  1 = two-operand instruction, 0 = operand A only
- src_addr_a  in  AW  address of operand A
- src_addr_b  in  AW  address of operand B
- mem_rdata  in  DATA_WIDTH  data memory read data, valid the cycle after the address is sampled
- mem_addr  out  AW  data memory read address (registered)
- mem_rd_en  out  1  read strobe (registered)
- operand_a  out  DATA_WIDTH  captured operand A
- operand_b  out  DATA_WIDTH  captured operand B; 0 when need_b=0
- ready  out  1  one-cycle pulse: operands valid
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; latched addresses and need_b 0.
  - Takes effect immediately, including mid-sequence.
- States: IDLE, REQ_A, RESP_A, REQ_B, RESP_B, DONE.
- IDLE, enable=1 at an edge:
  - Latch src_addr_a, src_addr_b and need_b; later input changes are ignored until the next start.
  - mem_addr<=addr_a, mem_rd_en<=1, operand_a<=0, operand_b<=0 -> REQ_A.
- REQ_A:
  - Memory samples the address at this edge.
  - mem_rd_en<=0 -> RESP_A.
- RESP_A: operand_a<=mem_rdata.
  - If need_b: mem_addr<=addr_b, mem_rd_en<=1 -> REQ_B.
  - Else: ready<=1 -> DONE.
- REQ_B: mem_rd_en<=0 -> RESP_B.
- RESP_B: operand_b<=mem_rdata, ready<=1 -> DONE.
- DONE:
  - ready<=0 -> IDLE unconditionally; the next start needs one IDLE edge.
  - Operands hold their values until the next start.
- Latency, counted from the start edge:
  - ready is high in the cycle after edge 4 (need_b=1) or edge 2 (need_b=0).
  - Back-to-back starts while enable stays high: one new result every 6 cycles (two-operand) or 4 cycles (single-operand).
- enable=0 in any state other than IDLE/DONE:
  - Abort to IDLE at that edge: mem_rd_en<=0, ready stays 0.
  - operand registers keep whatever was captured; no ready is emitted.
- enable=0 in DONE: the ready pulse still completes.
- Equal addresses (addr_a==addr_b): two reads are still issued; no special case.
- mem_addr holds its last value when mem_rd_en=0.
- Only the state register and latches are sequential; there are no combinational outputs.

Optional Feature:
- Macro: LOAD_FORWARD_EN.
- Defined:
  - Adds input ports fwd_valid (1), fwd_addr (AW) and fwd_data (DATA_WIDTH), driven by the save stage's write-back.
  - In RESP_A/RESP_B, if fwd_valid && fwd_addr == latched address, capture fwd_data instead of mem_rdata.
  - This resolves write-then-read hazards.
- Undefined: the ports are absent; operands always come from mem_rdata.

Decomposition:
- Shared package dsd_cpu_pkg:
  - State encoding typedef load_state_t, 3 bits, with IDLE=0.
  - Default DATA_WIDTH and DATA_MEMORY_SIZE constants, shared with the save stage.
- Sub-module: operand_capture. It holds one operand register plus the forwarding mux (compiled per macro) and is instantiated twice (A, B).
- The FSM stays in the top.

Test Plan:
- Reset mid-sequence: rst_n=0 while in REQ_B -> all outputs 0 immediately, state IDLE; after release, enable restarts cleanly.
- Two-operand read: mem[5]=8'h3C, mem[9]=8'hA1, enable=1, need_b=1 -> mem_addr 5 then 9; ready pulses 1 cycle after edge 4; operand_a=3C, operand_b=A1.
- Single-operand read: need_b=0, src_a=0, mem[0]=8'hFF -> ready after edge 2; operand_a=FF, operand_b=00; mem_rd_en pulsed exactly once.
- Abort: drop enable during RESP_A -> no ready, mem_rd_en=0, busy=0 next cycle; re-enable gives a full correct sequence.
- Sustained enable with addresses changed mid-sequence -> first result uses the latched addresses; the second result starts 6 cycles after the first start and uses the new addresses.
- LOAD_FORWARD_EN:
  - fwd_valid=1, fwd_addr=9, fwd_data=8'h55 during RESP_B with addr_b=9, mem[9]=A1 -> operand_b=55.
  - fwd_addr=8 -> operand_b=A1.

Source files
------------

// File: rtl/dsd_cpu_pkg.sv
// Shared CPU-datapath types: load-FSM state encoding and default memory geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: load_state_t (3-bit, IDLE=0), DEF_DATA_WIDTH, DEF_DATA_MEMORY_SIZE.
// The defaults are shared with the save stage so both sides agree on the
// word width and the memory depth.
package dsd_cpu_pkg;

    localparam int DEF_DATA_WIDTH       = 8;
    localparam int DEF_DATA_MEMORY_SIZE = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_A  = 3'd1,
        RESP_A = 3'd2,
        REQ_B  = 3'd3,
        RESP_B = 3'd4,
        DONE   = 3'd5
    } load_state_t;

endpackage

// File: rtl/operand_load_handler_if.sv
// Bundle between the operand loader, its controller and the data memory.
// Latency: n/a (wires only).
// Backpressure: none; enable is a level request, ready is a one-cycle pulse.
// Signals: enable/need_b/src_addr_a/src_addr_b (request), mem_addr/mem_rd_en/
// mem_rdata (memory read port), operand_a/operand_b/ready/busy (result).
// Optional macro LOAD_FORWARD_EN adds fwd_valid/fwd_addr/fwd_data from the
// save stage write-back.
// Modports: slave = operand loader, master = controller/memory side.
interface operand_load_handler_if
    import dsd_cpu_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int DATA_MEMORY_SIZE = DEF_DATA_MEMORY_SIZE
) ();
    localparam int AW = $clog2(DATA_MEMORY_SIZE);

    logic                  enable;
    logic                  need_b;
    logic [AW-1:0]         src_addr_a;
    logic [AW-1:0]         src_addr_b;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [AW-1:0]         mem_addr;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic                  ready;
    logic                  busy;
`ifdef LOAD_FORWARD_EN
    logic                  fwd_valid;
    logic [AW-1:0]         fwd_addr;
    logic [DATA_WIDTH-1:0] fwd_data;
`endif

    modport slave (
`ifdef LOAD_FORWARD_EN
        input  fwd_valid, fwd_addr, fwd_data,
`endif
        input  enable, need_b, src_addr_a, src_addr_b, mem_rdata,
        output mem_addr, mem_rd_en, operand_a, operand_b, ready, busy
    );

    modport master (
`ifdef LOAD_FORWARD_EN
        output fwd_valid, fwd_addr, fwd_data,
`endif
        output enable, need_b, src_addr_a, src_addr_b, mem_rdata,
        input  mem_addr, mem_rd_en, operand_a, operand_b, ready, busy
    );

endinterface

// File: rtl/operand_load_handler_capture.sv
// One operand register with optional write-back forwarding mux.
// Latency: captures on the edge where cap is high; output is registered.
// Backpressure: none; clr wins over cap, otherwise the value holds.
// Ports: clk, rst_n, clr (zero at start), cap (load), rdata (memory data),
// operand (registered result); with LOAD_FORWARD_EN also fwd_valid/fwd_addr/
// fwd_data and match_addr (the latched address this operand was read from).
module operand_capture
    import dsd_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef LOAD_FORWARD_EN
    ,
    parameter int AW = $clog2(DEF_DATA_MEMORY_SIZE)
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  cap,
    input  logic [DATA_WIDTH-1:0] rdata,
`ifdef LOAD_FORWARD_EN
    input  logic                  fwd_valid,
    input  logic [AW-1:0]         fwd_addr,
    input  logic [DATA_WIDTH-1:0] fwd_data,
    input  logic [AW-1:0]         match_addr,
`endif
    output logic [DATA_WIDTH-1:0] operand
);

    logic [DATA_WIDTH-1:0] sel_data;

`ifdef LOAD_FORWARD_EN
    // A write landing in the same cycle as our read response is newer than
    // what the memory returned, so it takes priority.
    assign sel_data = (fwd_valid && (fwd_addr == match_addr)) ? fwd_data : rdata;
`else
    assign sel_data = rdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand <= '0;
        end else if (clr) begin
            operand <= '0;
        end else if (cap) begin
            operand <= sel_data;
        end
    end

endmodule

// File: rtl/operand_load_handler.sv
// Fetches one or two operands from synchronous data memory for the execute/save path.
// Latency: ready pulses 2 edges (A only) or 4 edges (A and B) after the start edge.
// Backpressure: none; enable is a level request, dropping it mid-fetch aborts silently.
// Ports: clk, rst_n (async active-low), bus (operand_load_handler_if.slave).
// Optional macro LOAD_FORWARD_EN: operands may be taken from the save stage
// write-back instead of memory when the addresses match.
module operand_load_handler
    import dsd_cpu_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int DATA_MEMORY_SIZE = DEF_DATA_MEMORY_SIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    operand_load_handler_if.slave  bus
);

    localparam int AW = $clog2(DATA_MEMORY_SIZE);

    load_state_t   state;
    logic [AW-1:0] mem_addr_q;
    logic          mem_rd_en_q;
    logic          ready_q;
    logic          busy_q;
    logic [AW-1:0] addr_b_q;
    logic          need_b_q;
`ifdef LOAD_FORWARD_EN
    // Operand A's address is only needed again for the forwarding compare;
    // the memory request itself uses src_addr_a directly at the start edge.
    logic [AW-1:0] addr_a_q;
`endif

    logic start;
    logic cap_a;
    logic cap_b;

    // Capture strobes are qualified by enable so an abort edge never loads
    // a half-finished result.
    assign start = (state == IDLE)   && bus.enable;
    assign cap_a = (state == RESP_A) && bus.enable;
    assign cap_b = (state == RESP_B) && bus.enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            addr_b_q    <= '0;
            need_b_q    <= 1'b0;
`ifdef LOAD_FORWARD_EN
            addr_a_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.enable) begin
                        addr_b_q    <= bus.src_addr_b;
                        need_b_q    <= bus.need_b;
`ifdef LOAD_FORWARD_EN
                        addr_a_q    <= bus.src_addr_a;
`endif
                        mem_addr_q  <= bus.src_addr_a;
                        mem_rd_en_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= REQ_A;
                    end
                end
                REQ_A, REQ_B: begin
                    mem_rd_en_q <= 1'b0;
                    if (!bus.enable) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        state  <= (state == REQ_A) ? RESP_A : RESP_B;
                    end
                end
                RESP_A: begin
                    if (!bus.enable) begin
                        mem_rd_en_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else if (need_b_q) begin
                        mem_addr_q  <= addr_b_q;
                        mem_rd_en_q <= 1'b1;
                        state       <= REQ_B;
                    end else begin
                        ready_q     <= 1'b1;
                        state       <= DONE;
                    end
                end
                RESP_B: begin
                    if (!bus.enable) begin
                        mem_rd_en_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        ready_q     <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // Pulse completes regardless of enable; one IDLE edge
                    // always separates consecutive fetches.
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    mem_rd_en_q <= 1'b0;
                    ready_q     <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;

    operand_capture #(
        .DATA_WIDTH (DATA_WIDTH)
`ifdef LOAD_FORWARD_EN
        ,
        .AW         (AW)
`endif
    ) u_cap_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start),
        .cap        (cap_a),
        .rdata      (bus.mem_rdata),
`ifdef LOAD_FORWARD_EN
        .fwd_valid  (bus.fwd_valid),
        .fwd_addr   (bus.fwd_addr),
        .fwd_data   (bus.fwd_data),
        .match_addr (addr_a_q),
`endif
        .operand    (bus.operand_a)
    );

    // Operand B is cleared at start and never loaded for single-operand
    // instructions, which is what makes it read 0 in that case.
    operand_capture #(
        .DATA_WIDTH (DATA_WIDTH)
`ifdef LOAD_FORWARD_EN
        ,
        .AW         (AW)
`endif
    ) u_cap_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start),
        .cap        (cap_b),
        .rdata      (bus.mem_rdata),
`ifdef LOAD_FORWARD_EN
        .fwd_valid  (bus.fwd_valid),
        .fwd_addr   (bus.fwd_addr),
        .fwd_data   (bus.fwd_data),
        .match_addr (addr_b_q),
`endif
        .operand    (bus.operand_b)
    );

endmodule

// File: tb/tb_operand_load_handler.sv
// Bench for operand_load_handler: behavioural synchronous memory, directed
// fetches, and a scoreboard of expected operands and ready cycle popped by a
// monitor on every ready pulse.
module tb_operand_load_handler;
    import dsd_cpu_pkg::*;

    localparam int DW = 8;
    localparam int MS = 64;
    localparam int AW = $clog2(MS);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_load_handler_if #(.DATA_WIDTH(DW), .DATA_MEMORY_SIZE(MS)) bus ();

    operand_load_handler #(.DATA_WIDTH(DW), .DATA_MEMORY_SIZE(MS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous memory with one-cycle read latency
    logic [DW-1:0] mem [MS];
    always @(posedge clk) begin
        if (bus.mem_rd_en === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            at;
    } exp_t;
    exp_t sb[$];

    int            rd_cnt = 0;
    logic [AW-1:0] addr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n === 1'b1 && bus.ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("operand_a", 32'(bus.operand_a), 32'(e.a));
                chk("operand_b", 32'(bus.operand_b), 32'(e.b));
                chk("ready_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.mem_rd_en === 1'b1) begin
            rd_cnt++;
            addr_log.push_back(bus.mem_addr);
        end
    end

    task automatic run(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic nb,
                       input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        bit got;
        got = 1'b0;
        @(negedge clk);
        sb.push_back('{a: ea, b: (nb ? eb : 8'h00), at: cyc + 1 + (nb ? 4 : 2)});
        bus.src_addr_a = a;
        bus.src_addr_b = b;
        bus.need_b     = nb;
        bus.enable     = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        bus.enable = 1'b0;
        chk("ready_seen", 32'(got), 32'd1);
        @(negedge clk);
        chk("ready_pulse_width", 32'(bus.ready), 32'd0);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        chk({tag, "_mem_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
        chk({tag, "_operand_a"}, 32'(bus.operand_a), 32'd0);
        chk({tag, "_operand_b"}, 32'(bus.operand_b), 32'd0);
        chk({tag, "_ready"},     32'(bus.ready),     32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        bus.enable     = 1'b0;
        bus.need_b     = 1'b0;
        bus.src_addr_a = '0;
        bus.src_addr_b = '0;
`ifdef LOAD_FORWARD_EN
        bus.fwd_valid  = 1'b0;
        bus.fwd_addr   = '0;
        bus.fwd_data   = '0;
`endif
        for (int i = 0; i < MS; i++) mem[i] = 8'(i * 3 + 1);
        mem[0] = 8'hFF;
        mem[3] = 8'h77;
        mem[5] = 8'h3C;
        mem[7] = 8'h42;
        mem[9] = 8'hA1;

        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Two-operand read, address order 5 then 9
        rd_cnt = 0;
        addr_log.delete();
        run(6'd5, 6'd9, 1'b1, 8'h3C, 8'hA1);
        chk("two_op_rd_cnt", 32'(rd_cnt), 32'd2);
        chk("two_op_first_addr", 32'(addr_log.size() > 0 ? addr_log[0] : 6'h3F), 32'd5);
        chk("two_op_second_addr", 32'(addr_log.size() > 1 ? addr_log[1] : 6'h3F), 32'd9);
        chk("operand_a_hold", 32'(bus.operand_a), 32'h3C);

        // Single-operand read: B must read 0, exactly one read strobe
        rd_cnt = 0;
        run(6'd0, 6'd9, 1'b0, 8'hFF, 8'h00);
        chk("one_op_rd_cnt", 32'(rd_cnt), 32'd1);

        // Equal addresses: still two reads
        rd_cnt = 0;
        run(6'd5, 6'd5, 1'b1, 8'h3C, 8'h3C);
        chk("equal_addr_rd_cnt", 32'(rd_cnt), 32'd2);

        // Abort during RESP_A
        @(negedge clk);
        bus.src_addr_a = 6'd9;
        bus.src_addr_b = 6'd5;
        bus.need_b     = 1'b1;
        bus.enable     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.ready), 32'd0);
        chk("abort_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_operand_a", 32'(bus.operand_a), 32'd0);
        run(6'd9, 6'd5, 1'b1, 8'hA1, 8'h3C);

        // Sustained enable, addresses changed after the first start edge
        @(negedge clk);
        c0 = cyc;
        sb.push_back('{a: 8'h3C, b: 8'hA1, at: c0 + 5});
        sb.push_back('{a: 8'h77, b: 8'h42, at: c0 + 11});
        bus.src_addr_a = 6'd5;
        bus.src_addr_b = 6'd9;
        bus.need_b     = 1'b1;
        bus.enable     = 1'b1;
        @(negedge clk);
        bus.src_addr_a = 6'd3;
        bus.src_addr_b = 6'd7;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) n++;
            if (n == 2) break;
        end
        bus.enable = 1'b0;
        chk("sustained_results", 32'(n), 32'd2);
        @(negedge clk);
        chk("sustained_busy_end", 32'(bus.busy), 32'd0);

        // Reset asserted while in REQ_B
        @(negedge clk);
        bus.src_addr_a = 6'd5;
        bus.src_addr_b = 6'd9;
        bus.need_b     = 1'b1;
        bus.enable     = 1'b1;
        repeat (3) @(negedge clk);
        chk("req_b_addr", 32'(bus.mem_addr), 32'd9);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        bus.enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(6'd9, 6'd5, 1'b1, 8'hA1, 8'h3C);

`ifdef LOAD_FORWARD_EN
        bus.fwd_valid = 1'b1;
        bus.fwd_addr  = 6'd9;
        bus.fwd_data  = 8'h55;
        run(6'd5, 6'd9, 1'b1, 8'h3C, 8'h55);
        bus.fwd_addr  = 6'd8;
        run(6'd5, 6'd9, 1'b1, 8'h3C, 8'hA1);
        bus.fwd_valid = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
